// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with operand forwarding, ALU, and iterative mul/div unit with HI/LO
module ex_muldiv_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_flush,
  input  logic                      alu_src1,
  input  logic                      alu_src2,
  input  logic [4:0]                alu_ctl,
  input  logic                      alu_sign,
  input  logic [4:0]                shamt,
  input  logic [DATA_W-1:0]         data_a,
  input  logic [DATA_W-1:0]         data_b,
  input  logic [DATA_W-1:0]         imm,
  input  logic [DATA_W-1:0]         pc_ex,
  input  logic [1:0]                mem_to_reg,
  input  logic [2:0]                md_op,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_src,
  input  logic [SEL_W-1:0]          fwd1_sel,
  input  logic [SEL_W-1:0]          fwd2_sel,
  output logic [DATA_W-1:0]         ex_result,
  output logic [DATA_W-1:0]         ex_wr_data,
  output logic                      ex_zero,
  output logic                      md_stall
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] hi, lo, acc, q, m, op_a, op_b, in1, in2, alu_out;
  logic [DATA_W-1:0] mag_a, mag_b, acc_nx, q_nx, div_rem, div_quo;
  logic [DATA_W:0] mul_sum, div_sh;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic is_div, neg_q, neg_r, dz, div_ok;
  logic md_issue_op, md_hilo_op, md_sgn_in, md_div_in, sa, sb, issue;
  always_comb begin
    op_a = data_a;
    op_b = data_b;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fwd1_sel == SEL_W'(k)) op_a = fwd_src[(k-1)*DATA_W +: DATA_W];
      if (fwd2_sel == SEL_W'(k)) op_b = fwd_src[(k-1)*DATA_W +: DATA_W];
    end
  end
  assign in1 = alu_src1 ? DATA_W'(shamt) : op_a;
  assign in2 = alu_src2 ? imm : op_b;
  // ALU encoding: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT, 8 SLL, 9 SRL, 10 SRA, 11 LUI
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      5'd0:  alu_out = in1 & in2;
      5'd1:  alu_out = in1 | in2;
      5'd2:  alu_out = in1 + in2;
      5'd3:  alu_out = in1 ^ in2;
      5'd4:  alu_out = ~(in1 | in2);
      5'd6:  alu_out = in1 - in2;
      5'd7:  alu_out = DATA_W'(alu_sign ? ($signed(in1) < $signed(in2)) : (in1 < in2));
      5'd8:  alu_out = in2 << in1[SH_W-1:0];
      5'd9:  alu_out = in2 >> in1[SH_W-1:0];
      5'd10: alu_out = $signed(in2) >>> in1[SH_W-1:0];
      5'd11: alu_out = in2 << (DATA_W / 2);
      default: alu_out = '0;
    endcase
  end
  assign ex_zero    = alu_out == '0;
  assign ex_wr_data = op_b;
  assign ex_result  = (md_op == 3'd5) ? hi :
                      (md_op == 3'd6) ? lo :
                      (mem_to_reg == 2'b10) ? pc_ex + DATA_W'(4) : alu_out;
  assign md_issue_op = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign md_hilo_op  = (md_op != 3'd0) && (md_op != 3'd7);
  assign md_sgn_in   = (md_op == 3'd1) || (md_op == 3'd3);
  assign md_div_in   = (md_op == 3'd3) || (md_op == 3'd4);
  assign md_stall    = ex_valid && (state != IDLE) && md_hilo_op;
  assign issue       = ex_valid && !ex_flush && !md_stall && md_issue_op && (state == IDLE);
  assign sa    = md_sgn_in && op_a[DATA_W-1];
  assign sb    = md_sgn_in && op_b[DATA_W-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;
  // Multiply: acc:q shifts right, adding m into acc when the multiplier LSB is set.
  // Divide: acc is the partial remainder, q shifts in quotient bits from the right.
  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {acc, q[DATA_W-1]};
    div_ok   = div_sh >= {1'b0, m};
    acc_nx   = is_div ? (div_ok ? div_sh[DATA_W-1:0] - m : div_sh[DATA_W-1:0]) : mul_sum[DATA_W:1];
    q_nx     = is_div ? {q[DATA_W-2:0], div_ok} : {mul_sum[0], q[DATA_W-1:1]};
    prod     = {acc, q};
    prod_fix = neg_q ? -prod : prod;
    div_rem  = neg_r ? -acc : acc;
    div_quo  = dz ? '1 : (neg_q ? -q : q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state  <= BUSY;
          cnt    <= '0;
          acc    <= '0;
          q      <= md_div_in ? mag_a : mag_b;
          m      <= md_div_in ? mag_b : mag_a;
          is_div <= md_div_in;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          dz     <= md_div_in && (op_b == '0);
        end
        BUSY: begin
          acc   <= acc_nx;
          q     <= q_nx;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_W'(DATA_W - 1)) ? FIXUP : BUSY;
        end
        FIXUP: begin
          hi    <= is_div ? div_rem : prod_fix[2*DATA_W-1:DATA_W];
          lo    <= is_div ? div_quo : prod_fix[DATA_W-1:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
